// File: rtl/mem_line_responder.sv
// Cache-line responder: splits a WORD_W*WORDS line into word beats on the physical
// memory bus, reassembles read beats, and pulses mem_resp once the line completes.
module mem_line_responder #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 8,
  parameter int OFFS_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [15:0]              mem_address,
  input  logic [WORD_W*WORDS-1:0]  mem_wdata,
  output logic [WORD_W*WORDS-1:0]  mem_rdata,
  output logic                     mem_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [15:0]              pmem_address,
  output logic [WORD_W-1:0]        pmem_wdata,
  input  logic [WORD_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp
);

  localparam int          LINE_W     = WORD_W * WORDS;
  localparam int          BEAT_W     = $clog2(WORDS);
  localparam logic [15:0] WORD_BYTES = 16'(WORD_W / 8);
  localparam logic [15:0] OFFS_MASK  = 16'((1 << OFFS_W) - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_BEAT  = 2'd1,
    WRITE_BEAT = 2'd2,
    RESPOND    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [15:0]         line_base;
  logic [LINE_W-1:0]   wbuf;
  logic [LINE_W-1:0]   rbuf;
  logic                accept_rd, accept_wr;
  logic                beat_done, last_beat;

  assign last_beat    = (beat == BEAT_W'(WORDS - 1));
  assign beat_done    = pmem_resp && ((state == READ_BEAT) || (state == WRITE_BEAT));
  assign pmem_address = line_base + (16'(beat) * WORD_BYTES);
  assign pmem_wdata   = wbuf[beat*WORD_W +: WORD_W];
  assign mem_rdata    = rbuf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read has priority; a write still held after the read line is picked up on the next IDLE pass.
  always_comb begin
    state_nxt  = state;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read) begin
          accept_rd = 1'b1;
          state_nxt = READ_BEAT;
        end else if (mem_write) begin
          accept_wr = 1'b1;
          state_nxt = WRITE_BEAT;
        end
      end
      READ_BEAT: begin
        pmem_read = 1'b1;
        if (pmem_resp && last_beat) state_nxt = RESPOND;
      end
      WRITE_BEAT: begin
        pmem_write = 1'b1;
        if (pmem_resp && last_beat) state_nxt = RESPOND;
      end
      RESPOND: begin
        mem_resp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at acceptance; later changes on the request side are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat      <= '0;
      line_base <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
    end else begin
      if (accept_rd || accept_wr) begin
        line_base <= mem_address & ~OFFS_MASK;
        beat      <= '0;
      end
      if (accept_wr) wbuf <= mem_wdata;
      if (beat_done) begin
        if (state == READ_BEAT) rbuf[beat*WORD_W +: WORD_W] <= pmem_rdata;
        beat <= last_beat ? '0 : beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: stimulus queues expected beats/lines,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_line_responder;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [15:0]   mem_address = '0;
  logic [127:0]  mem_wdata = '0;
  logic [127:0]  mem_rdata;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [15:0]   pmem_wdata;
  logic [15:0]   pmem_rdata;
  logic          pmem_resp;

  int            tests = 0;
  int            fails = 0;
  int            wait_cycles = 0;
  int            wait_cnt = 0;
  logic [15:0]   rd_xor = '0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t         exp_beats[$];
  logic [127:0]  exp_lines[$];

  mem_line_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Physical memory: read data is address XOR a per-test pattern; each beat waits wait_cycles.
  assign pmem_resp  = (pmem_read || pmem_write) && (wait_cnt >= wait_cycles);
  assign pmem_rdata = pmem_address ^ rd_xor;

  always_ff @(posedge clk) begin
    if ((pmem_read || pmem_write) && !pmem_resp) wait_cnt <= wait_cnt + 1;
    else                                         wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if ((pmem_read || pmem_write) && pmem_resp) begin
        if (exp_beats.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got addr %h, expected no beat", pmem_address);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_write_strobe", 128'(pmem_write), 128'(b.wr));
          check("beat_read_strobe", 128'(pmem_read), 128'(!b.wr));
          check("beat_addr", 128'(pmem_address), 128'(b.addr));
          if (b.wr) check("beat_wdata", 128'(pmem_wdata), 128'(b.data));
        end
      end
      if (mem_resp) begin
        if (exp_lines.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got mem_resp=1, expected 0");
        end else begin
          check("resp_rdata", mem_rdata, exp_lines.pop_front());
        end
      end
    end
  end

  task automatic push_beats(input bit wr, input logic [15:0] base, input logic [127:0] line, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.wr   = wr;
      b.addr = base + 16'(2 * i);
      b.data = line[i*16 +: 16];
      exp_beats.push_back(b);
    end
  endtask

  // Called right after the request is driven (#1 past an edge): counts edges to mem_resp.
  task automatic wait_resp(input int exp_edges, input bit exp_rd, input bit scramble);
    int edges;
    edges = 0;
    @(negedge clk);
    check("idle_gap_strobes", 128'(pmem_read || pmem_write), 128'(0));
    check("idle_gap_resp", 128'(mem_resp), 128'(0));
    forever begin
      @(posedge clk);
      edges++;
      if (edges == 1 && scramble) begin
        #1;
        mem_address = ~mem_address;
        mem_wdata   = ~mem_wdata;
      end
      @(negedge clk);
      if (edges == 1) begin
        check("first_beat_read", 128'(pmem_read), 128'(exp_rd));
        check("first_beat_write", 128'(pmem_write), 128'(!exp_rd));
      end
      if (mem_resp) break;
      if (edges > 200) begin
        tests++; fails++;
        $display("FAIL resp_timeout: got no mem_resp after %0d cycles, expected %0d", edges, exp_edges);
        break;
      end
    end
    check("latency", 128'(edges), 128'(exp_edges));
  endtask

  task automatic do_line(input bit rd, input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                         input logic [15:0] xr, input int waits, input int exp_edges, input bit scramble);
    @(posedge clk);
    #1;
    mem_read    = rd;
    mem_write   = wr;
    mem_address = addr;
    mem_wdata   = wd;
    rd_xor      = xr;
    wait_cycles = waits;
    wait_resp(exp_edges, rd, scramble);
  endtask

  task automatic drop_req();
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  localparam logic [127:0] LINE_1230 = 128'h123E_123C_123A_1238_1236_1234_1232_1230;
  localparam logic [127:0] WLINE_A0  = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [127:0] LINE_2000 = 128'h2F01_2F03_2F05_2F07_2F09_2F0B_2F0D_2F0F;
  localparam logic [127:0] WLINE_11  = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] LINE_0100 = 128'h01F1_01F3_01F5_01F7_01F9_01FB_01FD_01FF;
  localparam logic [127:0] LINE_0000 = 128'h5A54_5A56_5A50_5A52_5A5C_5A5E_5A58_5A5A;
  localparam logic [127:0] LINE_0010 = 128'hC3DD_C3DF_C3D9_C3DB_C3D5_C3D7_C3D1_C3D3;

  initial begin
    // Reset asserted mid-cycle: outputs must clear without a clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_pmem_read", 128'(pmem_read), 128'(0));
    check("rst_pmem_write", 128'(pmem_write), 128'(0));
    check("rst_mem_resp", 128'(mem_resp), 128'(0));
    check("rst_pmem_address", 128'(pmem_address), 128'(0));
    check("rst_pmem_wdata", 128'(pmem_wdata), 128'(0));
    check("rst_mem_rdata", mem_rdata, 128'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_strobes", 128'(pmem_read || pmem_write), 128'(0));
      check("post_rst_resp", 128'(mem_resp), 128'(0));
    end

    // Zero-wait read of the line containing 0x1234
    push_beats(1'b0, 16'h1230, '0, 8);
    exp_lines.push_back(LINE_1230);
    do_line(1'b1, 1'b0, 16'h1234, '0, 16'h0000, 0, 9, 1'b1);
    drop_req();

    // Stalled write: 3 wait cycles per beat, read line retained
    push_beats(1'b1, 16'h0040, WLINE_A0, 8);
    exp_lines.push_back(LINE_1230);
    do_line(1'b0, 1'b1, 16'h0040, WLINE_A0, 16'h0000, 3, 33, 1'b1);
    drop_req();

    // Read and write together: read first, then the still-held write
    push_beats(1'b0, 16'h2000, '0, 8);
    exp_lines.push_back(LINE_2000);
    do_line(1'b1, 1'b1, 16'h2006, WLINE_11, 16'h0F0F, 0, 9, 1'b0);
    push_beats(1'b1, 16'h2000, WLINE_11, 8);
    exp_lines.push_back(LINE_2000);
    @(posedge clk);
    #1;
    mem_read    = 1'b0;
    wait_cycles = 1;
    wait_resp(17, 1'b0, 1'b0);
    drop_req();

    // Reset during beat 4 of a read
    repeat (2) @(posedge clk);
    #1;
    mem_read    = 1'b1;
    mem_address = 16'h0100;
    rd_xor      = 16'h00FF;
    wait_cycles = 0;
    push_beats(1'b0, 16'h0100, '0, 4);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_beat4_read", 128'(pmem_read), 128'(1));
    check("pre_rst_beat4_addr", 128'(pmem_address), 128'(16'h0108));
    reset = 1'b1;
    #1;
    check("midrst_pmem_read", 128'(pmem_read), 128'(0));
    check("midrst_mem_rdata", mem_rdata, 128'(0));
    check("midrst_mem_resp", 128'(mem_resp), 128'(0));
    mem_read = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("after_midrst_idle", 128'(pmem_read || mem_resp), 128'(0));
    end
    push_beats(1'b0, 16'h0100, '0, 8);
    exp_lines.push_back(LINE_0100);
    do_line(1'b1, 1'b0, 16'h0100, '0, 16'h00FF, 0, 9, 1'b1);
    drop_req();

    // Back-to-back reads with a single idle cycle between lines
    push_beats(1'b0, 16'h0000, '0, 8);
    exp_lines.push_back(LINE_0000);
    do_line(1'b1, 1'b0, 16'h0000, '0, 16'h5A5A, 0, 9, 1'b0);
    push_beats(1'b0, 16'h0010, '0, 8);
    exp_lines.push_back(LINE_0010);
    do_line(1'b1, 1'b0, 16'h001F, '0, 16'hC3C3, 0, 9, 1'b1);
    drop_req();

    repeat (4) @(posedge clk);
    check("pending_beats", 128'(exp_beats.size()), 128'(0));
    check("pending_lines", 128'(exp_lines.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end

endmodule
